// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared types and helpers for the mm_sram_responder slice
package mm_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int ADDR_W = 25;

    typedef logic [DATA_W-1:0] mm_word_t;
    typedef logic [BE_W-1:0]   mm_be_n_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        mm_be_n_t          be_n;
        mm_word_t          wdata;
        logic              rd;
        logic              wr;
    } mm_req_t;

    // Overlay the enabled (active-low) byte lanes of wdata onto old.
    function automatic mm_word_t merge_bytes(mm_word_t old, mm_word_t wdata, mm_be_n_t be_n);
        mm_word_t r;
        r = old;
        for (int i = 0; i < BE_W; i++) begin
            if (!be_n[i]) begin
                r[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mm_read_pipe.sv
// rtl/mm_read_pipe.sv - LATENCY-stage valid/data shift register with synchronous clear
module mm_read_pipe
    import mm_pkg::*;
#(
    parameter int LATENCY = 3
) (
    input  logic     clk,
    input  logic     clr,
    input  logic     in_valid,
    input  mm_word_t in_data,
    output logic     out_valid,
    output mm_word_t out_data
);

    logic [LATENCY-1:0] valid_q;
    mm_word_t           data_q [LATENCY];

    always_ff @(posedge clk) begin
        if (clr) begin
            valid_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            data_q[0]  <= in_data;
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/mm_sram_responder.sv
// rtl/mm_sram_responder.sv - Avalon-MM SRAM responder; MM_REFRESH_STALL_EN adds periodic refresh stalls
module mm_sram_responder
    import mm_pkg::*;
#(
    parameter int DEPTH          = 4096,
    parameter int READ_LATENCY   = 3,
    parameter int MAX_PENDING    = 2,
    parameter int REFRESH_PERIOD = 780,
    parameter int REFRESH_CYCLES = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] address,
    input  mm_be_n_t          byteenable_n,
    input  logic              chipselect,
    input  logic              read_n,
    input  logic              write_n,
    input  mm_word_t          writedata,
    output mm_word_t          readdata,
    output logic              readdatavalid,
    output logic              waitrequest,
    output logic              protocol_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(MAX_PENDING + 1);

    mm_req_t          req;
    logic [IDX_W-1:0] idx;
    logic             unused_addr_hi;
    logic             accept;
    logic             wr_accept;
    logic             rd_accept;
    logic             both_accept;
    logic             reset_q;
    logic             refresh_active;
    logic [CNT_W-1:0] outstanding;
    logic             full;
    logic             cap_valid;
    mm_word_t         cap_data;
    mm_word_t         mem [DEPTH];

    always_comb begin
        req.addr  = address;
        req.be_n  = byteenable_n;
        req.wdata = writedata;
        req.rd    = ~read_n;
        req.wr    = ~write_n;
    end

    // Upper address bits are deliberately ignored so the array aliases.
    assign idx            = req.addr[IDX_W-1:0];
    assign unused_addr_hi = ^req.addr[ADDR_W-1:IDX_W];

    assign full        = (outstanding == CNT_W'(MAX_PENDING));
    assign waitrequest = Reset | reset_q | full | refresh_active;

    assign accept      = chipselect & ~waitrequest & (req.rd | req.wr);
    assign wr_accept   = accept & req.wr;
    assign rd_accept   = accept & req.rd & ~req.wr;
    assign both_accept = accept & req.rd & req.wr;

    always_ff @(posedge Clk) begin
        reset_q <= Reset;
    end

    always_ff @(posedge Clk) begin
        if (wr_accept) begin
            mem[idx] <= merge_bytes(mem[idx], req.wdata, req.be_n);
        end
    end

    // Capture at the accept edge so later writes cannot disturb this read.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cap_valid <= 1'b0;
            cap_data  <= '0;
        end else begin
            cap_valid <= rd_accept;
            if (rd_accept) begin
                cap_data <= mem[idx];
            end
        end
    end

    mm_read_pipe #(
        .LATENCY(READ_LATENCY)
    ) u_read_pipe (
        .clk      (Clk),
        .clr      (Reset),
        .in_valid (cap_valid),
        .in_data  (cap_data),
        .out_valid(readdatavalid),
        .out_data (readdata)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            outstanding <= '0;
        end else begin
            case ({rd_accept, readdatavalid})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            protocol_err <= 1'b0;
        end else if (both_accept) begin
            protocol_err <= 1'b1;
        end
    end

`ifdef MM_REFRESH_STALL_EN
    localparam int RCW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
    localparam int RLW = $clog2(REFRESH_CYCLES + 1);

    logic [RCW-1:0] ref_cnt;
    logic [RLW-1:0] ref_left;
    logic           ref_wrap;

    assign ref_wrap = (ref_cnt == RCW'(REFRESH_PERIOD - 1));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ref_cnt  <= '0;
            ref_left <= '0;
        end else begin
            ref_cnt <= ref_wrap ? '0 : ref_cnt + 1'b1;
            if (ref_wrap) begin
                ref_left <= RLW'(REFRESH_CYCLES);
            end else if (ref_left != '0) begin
                ref_left <= ref_left - 1'b1;
            end
        end
    end

    assign refresh_active = (ref_left != '0);
`else
    assign refresh_active = 1'b0;
`endif

endmodule

// File: tb/tb_mm_sram_responder.sv
// tb/tb_mm_sram_responder.sv - scoreboard bench for mm_sram_responder
module tb_mm_sram_responder;
    import mm_pkg::*;

    localparam int L     = 3;
    localparam int MP    = 2;
    localparam int DEPTH = 4096;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [24:0] address = '0;
    logic [3:0]  byteenable_n = 4'hF;
    logic        chipselect = 1'b0;
    logic        read_n = 1'b1;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        waitrequest;
    logic        protocol_err;

    mm_sram_responder #(
        .DEPTH(DEPTH), .READ_LATENCY(L), .MAX_PENDING(MP),
        .REFRESH_PERIOD(20), .REFRESH_CYCLES(4)
    ) dut (
        .Clk(Clk), .Reset(Reset), .address(address), .byteenable_n(byteenable_n),
        .chipselect(chipselect), .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .readdata(readdata), .readdatavalid(readdatavalid), .waitrequest(waitrequest),
        .protocol_err(protocol_err)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sb[$];
    exp_t        head;
    logic [31:0] model [DEPTH];
    int          stalls = 0;
    int          hi, lo, budget;

    always @(negedge Clk) begin
        if (readdatavalid) begin
            if (sb.size() == 0) begin
                check("spurious_rdv", 32'd1, 32'd0);
            end else begin
                head = sb.pop_front();
                check("rd_data", readdata, head.data);
                check("rd_time", cyc, head.due);
            end
        end
    end

    task automatic issue(input bit rd, input bit wr, input logic [24:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
        int          wait_cnt;
        logic [11:0] ix;
        exp_t        e;
        ix = a[11:0];
        @(negedge Clk);
        chipselect = 1'b1; read_n = !rd; write_n = !wr;
        address = a; byteenable_n = be; writedata = wd;
        wait_cnt = 0;
        while (waitrequest && wait_cnt < 50) begin
            stalls++;
            wait_cnt++;
            @(negedge Clk);
        end
        if (wait_cnt >= 50) begin
            check("accept_timeout", 32'd1, 32'd0);
        end else begin
            @(posedge Clk);
            #1;
            if (wr) begin
                for (int i = 0; i < 4; i++)
                    if (!be[i]) model[ix][8*i +: 8] = wd[8*i +: 8];
            end else if (rd) begin
                e.data = model[ix];
                e.due  = cyc + L;
                sb.push_back(e);
            end
        end
        chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            n++;
            @(negedge Clk);
        end
        check("drain", sb.size(), 0);
    endtask

    task automatic leave_reset();
        @(posedge Clk);
        #1 Reset = 1'b0;
        @(negedge Clk);
        check("wr_one_after_reset", waitrequest, 1);
        @(negedge Clk);
        check("wr_low_after_reset", waitrequest, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge Clk);
        check("wr_in_reset", waitrequest, 1);
        check("rdv_in_reset", readdatavalid, 0);
        check("rdata_in_reset", readdata, 0);
        check("perr_in_reset", protocol_err, 0);
        leave_reset();
        repeat (3) @(negedge Clk);
        check("perr_idle", protocol_err, 0);

        issue(0, 1, 25'h10, 4'b0000, 32'hDEADBEEF);
        issue(1, 0, 25'h10, 4'hF, 32'h0);
        drain();

        issue(0, 1, 25'h5, 4'b0000, 32'hDEADBEEF);
        issue(0, 1, 25'h5, 4'b1010, 32'h11223344);
        issue(1, 0, 25'h5, 4'hF, 32'h0);
        issue(0, 1, 25'h5, 4'b1111, 32'h0);
        issue(1, 0, 25'h5, 4'hF, 32'h0);
        drain();

        for (int i = 1; i <= 3; i++) issue(0, 1, 25'(i), 4'b0000, 32'hA5000000 | 32'(i * 17));
        stalls = 0;
        for (int i = 1; i <= 3; i++) issue(1, 0, 25'(i), 4'hF, 32'h0);
        check("third_read_stalled", 32'(stalls != 0), 32'd1);
        drain();

        issue(0, 1, 25'h20, 4'b0000, 32'h0BADF00D);
        issue(1, 0, 25'h20, 4'hF, 32'h0);
        issue(0, 1, 25'h20, 4'b0000, 32'h12345678);
        issue(1, 0, 25'h20, 4'hF, 32'h0);
        drain();

        issue(0, 1, 25'h7, 4'b0000, 32'hCAFE0007);
        issue(1, 0, 25'd4096 + 25'd7, 4'hF, 32'h0);
        issue(0, 1, 25'h1FFFFFF, 4'b0000, 32'h5A5AFFFF);
        issue(1, 0, 25'hFFF, 4'hF, 32'h0);
        drain();

        issue(1, 1, 25'h9, 4'b0000, 32'h99990009);
        @(negedge Clk);
        check("perr_set", protocol_err, 1);
        repeat (6) @(negedge Clk);
        issue(1, 0, 25'h9, 4'hF, 32'h0);
        drain();
        check("perr_sticky", protocol_err, 1);

        issue(1, 0, 25'h1, 4'hF, 32'h0);
        issue(1, 0, 25'h2, 4'hF, 32'h0);
        Reset = 1'b1;
        sb.delete();
        repeat (3) @(negedge Clk);
        check("outstanding_cleared", 32'(dut.outstanding), 0);
        check("perr_cleared", protocol_err, 0);
        leave_reset();
        repeat (8) @(negedge Clk);
        issue(1, 0, 25'h3, 4'hF, 32'h0);
        drain();

`ifdef MM_REFRESH_STALL_EN
        budget = 0;
        while (waitrequest && budget < 40) begin budget++; @(negedge Clk); end
        budget = 0;
        while (!waitrequest && budget < 40) begin budget++; @(negedge Clk); end
        hi = 0;
        while (waitrequest && hi < 30) begin hi++; @(negedge Clk); end
        lo = 0;
        while (!waitrequest && lo < 30) begin lo++; @(negedge Clk); end
        check("refresh_high_len", hi, 4);
        check("refresh_low_len", lo, 16);
        budget = 0;
        while (waitrequest && budget < 40) begin budget++; @(negedge Clk); end
        repeat (14) @(negedge Clk);
        issue(1, 0, 25'h10, 4'hF, 32'h0);
        @(negedge Clk);
        check("stall_after_read", waitrequest, 1);
        drain();
`endif

        repeat (5) @(negedge Clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
